// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: state encoding, widths,
// default golden table and a lowest-differing-bit helper.
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int IDX_W = 3;
  localparam int CNT_W = 4;
  localparam logic [7:0] EXPECTED_DEFAULT = 8'h31;

  // Lowest bit position where the two tables differ; 0 when they match.
  function automatic logic [IDX_W-1:0] first_mismatch(input logic [7:0] tbl,
                                                      input logic [7:0] golden);
    logic [7:0]       diff;
    logic [IDX_W-1:0] pos;
    diff = tbl ^ golden;
    pos  = '0;
    for (int i = 7; i >= 0; i--) begin
      if (diff[i]) pos = IDX_W'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Down-counter timing how long each vector is held before sampling.
// tc is high on the last hold cycle (count == 1).
module settle_counter
  import sweeper_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CNT_W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight {a,b,c} vectors into a 3-input function and captures y.
// Optional pass/mismatch_idx compare outputs are built when SWEEP_CHECK_EN is defined.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int         SETTLE   = 1,
  parameter logic [7:0] EXPECTED = EXPECTED_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out
`ifdef SWEEP_CHECK_EN
  ,
  output logic             pass,
  output logic [IDX_W-1:0] mismatch_idx
`endif
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       table_q, table_d;
  logic [2:0]       abc_q, abc_d;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_tc;

  settle_counter u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(SETTLE)),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= '0;
      abc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      abc_q   <= abc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    table_d  = table_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = DRIVE;
          idx_d    = '0;
          table_d  = '0;
          cnt_load = 1'b1;
        end
      end
      DRIVE: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_d = SAMPLE;
      end
      SAMPLE: begin
        table_d[idx_q] = y;
        if (idx_q == IDX_W'(7)) begin
          state_d = DONE;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          state_d  = DRIVE;
          cnt_load = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Vector register follows the next state so a/b/c are flop outputs.
    abc_d = ((state_d == DRIVE) || (state_d == SAMPLE)) ? idx_d : 3'b000;
  end

  always_comb begin
    busy      = (state_q == DRIVE) || (state_q == SAMPLE);
    done      = (state_q == DONE);
    a         = abc_q[2];
    b         = abc_q[1];
    c         = abc_q[0];
    table_out = table_q;
  end

`ifdef SWEEP_CHECK_EN
  logic             pass_q;
  logic [IDX_W-1:0] midx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pass_q <= 1'b0;
      midx_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      pass_q <= 1'b0;
      midx_q <= '0;
    end else if ((state_q == SAMPLE) && (state_d == DONE)) begin
      pass_q <= (table_d == EXPECTED);
      midx_q <= first_mismatch(table_d, EXPECTED);
    end
  end

  assign pass         = pass_q;
  assign mismatch_idx = midx_q;
`else
  logic unused_expected;
  assign unused_expected = ^EXPECTED;
`endif

endmodule
